// File: rtl/toom8_pkg.sv
// Shared widths, types and helpers for the Toom-8 multiplier front end.
// Operands are split into eight 128-bit limbs; chunks carry one spare MSB for evaluation carries.
package toom8_pkg;

  localparam int OP_W    = 1024;
  localparam int LIMB_W  = 128;
  localparam int CHUNK_W = 129;
  localparam int N_LIMBS = 8;
  localparam int PROD_W  = 2048;

  // Column k = i+j gathers up to eight 256-bit partial products, hence three guard bits.
  localparam int N_COLS = 2 * N_LIMBS - 1;
  localparam int COL_W  = 2 * LIMB_W + 3;

  typedef logic [LIMB_W-1:0]  limb_t;
  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef limb_t [N_LIMBS-1:0] limb_vec_t;

  function automatic col_t limb_mul(input limb_t a, input limb_t b);
    return col_t'(a) * col_t'(b);
  endfunction

  function automatic chunk_t limb_to_chunk(input limb_t l);
    return {1'b0, l};
  endfunction

endpackage

// File: rtl/toom_8_splitting_if.sv
// Operand/result bundle between the Toom-8 front end and its neighbours.
// The slave side is the splitter itself; the master side drives operands and consumes results.
interface toom_8_splitting_if;
  import toom8_pkg::*;

  logic [OP_W-1:0]   X;
  logic [OP_W-1:0]   Y;
  logic [PROD_W-1:0] product;
  chunk_t A_chunk0, A_chunk1, A_chunk2, A_chunk3;
  chunk_t A_chunk4, A_chunk5, A_chunk6, A_chunk7;
  chunk_t B_chunk0, B_chunk1, B_chunk2, B_chunk3;
  chunk_t B_chunk4, B_chunk5, B_chunk6, B_chunk7;

  modport master (
    output X, Y,
    input  product,
    input  A_chunk0, A_chunk1, A_chunk2, A_chunk3,
    input  A_chunk4, A_chunk5, A_chunk6, A_chunk7,
    input  B_chunk0, B_chunk1, B_chunk2, B_chunk3,
    input  B_chunk4, B_chunk5, B_chunk6, B_chunk7
  );

  modport slave (
    input  X, Y,
    output product,
    output A_chunk0, A_chunk1, A_chunk2, A_chunk3,
    output A_chunk4, A_chunk5, A_chunk6, A_chunk7,
    output B_chunk0, B_chunk1, B_chunk2, B_chunk3,
    output B_chunk4, B_chunk5, B_chunk6, B_chunk7
  );

endinterface

// File: rtl/toom_8_splitting_schoolbook_mul.sv
// Exact 1024x1024 product from registered limb arrays, accumulated column by column.
// Registered output: one cycle from limbs to product.
module toom8_schoolbook_mul
  import toom8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  limb_vec_t         a_limbs,
  input  limb_vec_t         b_limbs,
  output logic [PROD_W-1:0] product
);

  col_t              col [N_COLS];
  logic [PROD_W-1:0] product_p2_d;
  logic [PROD_W-1:0] product_p2_q;

  always_comb begin
    for (int k = 0; k < N_COLS; k++) begin
      col[k] = '0;
    end
    for (int i = 0; i < N_LIMBS; i++) begin
      for (int j = 0; j < N_LIMBS; j++) begin
        col[i+j] = col[i+j] + limb_mul(a_limbs[i], b_limbs[j]);
      end
    end
    // Columns overlap by their guard bits, so the final sum carries across limb boundaries.
    product_p2_d = '0;
    for (int k = 0; k < N_COLS; k++) begin
      product_p2_d = product_p2_d + (PROD_W'(col[k]) << (LIMB_W * k));
    end
  end

  // Stage 2: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_p2_q <= '0;
    end else begin
      product_p2_q <= product_p2_d;
    end
  end

  assign product = product_p2_q;

endmodule

// File: rtl/toom_8_splitting.sv
// Toom-8 front end: registers both operands as 128-bit limbs, exports them as 129-bit chunks,
// and forms the exact 2048-bit reference product one stage later.
module toom_8_splitting
  import toom8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  toom_8_splitting_if.slave  bus
);

  limb_vec_t         a_limb_p1_d;
  limb_vec_t         b_limb_p1_d;
  limb_vec_t         a_limb_p1_q;
  limb_vec_t         b_limb_p1_q;
  chunk_t            a_chunk [N_LIMBS];
  chunk_t            b_chunk [N_LIMBS];
  logic [PROD_W-1:0] product_w;

  for (genvar i = 0; i < N_LIMBS; i++) begin : g_split
    assign a_limb_p1_d[i] = bus.X[LIMB_W*i +: LIMB_W];
    assign b_limb_p1_d[i] = bus.Y[LIMB_W*i +: LIMB_W];
    assign a_chunk[i]     = limb_to_chunk(a_limb_p1_q[i]);
    assign b_chunk[i]     = limb_to_chunk(b_limb_p1_q[i]);
  end

  // Stage 1: limb registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_limb_p1_q <= '0;
      b_limb_p1_q <= '0;
    end else begin
      a_limb_p1_q <= a_limb_p1_d;
      b_limb_p1_q <= b_limb_p1_d;
    end
  end

  toom8_schoolbook_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_limbs (a_limb_p1_q),
    .b_limbs (b_limb_p1_q),
    .product (product_w)
  );

  assign bus.product  = product_w;

  assign bus.A_chunk0 = a_chunk[0];
  assign bus.A_chunk1 = a_chunk[1];
  assign bus.A_chunk2 = a_chunk[2];
  assign bus.A_chunk3 = a_chunk[3];
  assign bus.A_chunk4 = a_chunk[4];
  assign bus.A_chunk5 = a_chunk[5];
  assign bus.A_chunk6 = a_chunk[6];
  assign bus.A_chunk7 = a_chunk[7];

  assign bus.B_chunk0 = b_chunk[0];
  assign bus.B_chunk1 = b_chunk[1];
  assign bus.B_chunk2 = b_chunk[2];
  assign bus.B_chunk3 = b_chunk[3];
  assign bus.B_chunk4 = b_chunk[4];
  assign bus.B_chunk5 = b_chunk[5];
  assign bus.B_chunk6 = b_chunk[6];
  assign bus.B_chunk7 = b_chunk[7];

endmodule

// File: tb/tb_toom_8_splitting.sv
// Directed bench for the Toom-8 front end: reset, limb split, hand-computed products,
// boundary operands and a back-to-back stream with a mid-stream reset.
module tb_toom_8_splitting;
  import toom8_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toom_8_splitting_if bus ();

  toom_8_splitting dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  chunk_t a_ch [N_LIMBS];
  chunk_t b_ch [N_LIMBS];

  always_comb begin
    a_ch[0] = bus.A_chunk0; a_ch[1] = bus.A_chunk1; a_ch[2] = bus.A_chunk2; a_ch[3] = bus.A_chunk3;
    a_ch[4] = bus.A_chunk4; a_ch[5] = bus.A_chunk5; a_ch[6] = bus.A_chunk6; a_ch[7] = bus.A_chunk7;
    b_ch[0] = bus.B_chunk0; b_ch[1] = bus.B_chunk1; b_ch[2] = bus.B_chunk2; b_ch[3] = bus.B_chunk3;
    b_ch[4] = bus.B_chunk4; b_ch[5] = bus.B_chunk5; b_ch[6] = bus.B_chunk6; b_ch[7] = bus.B_chunk7;
  end

  // Reports the first differing 128-bit limb so the line stays short.
  task automatic check(input string tag, input logic [PROD_W-1:0] obs, input logic [PROD_W-1:0] exp);
    int idx;
    idx = 0;
    for (int k = 15; k >= 0; k--) begin
      if (obs[128*k +: 128] !== exp[128*k +: 128]) idx = k;
    end
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s limb%0d observed=%h expected=%h", tag, idx,
             obs[128*idx +: 128], exp[128*idx +: 128]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] r;
    for (int w = 0; w < OP_W / 32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [PROD_W-1:0] ref_mul(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
    return {{OP_W{1'b0}}, x} * {{OP_W{1'b0}}, y};
  endfunction

  function automatic logic [PROD_W-1:0] ext_chunk(input chunk_t c);
    return PROD_W'(c);
  endfunction

  function automatic logic [PROD_W-1:0] ext_limb(input limb_t l);
    return PROD_W'({1'b0, l});
  endfunction

  int exp_ch [N_LIMBS] = '{253, 2, 3, 4, 5, 6, 7, 8};
  int exp_pl [16] = '{64009, 1012, 1522, 2036, 2555, 3080, 3612, 4152,
                      147, 164, 170, 164, 145, 112, 64, 0};

  logic [OP_W-1:0]   x_dir;
  logic [OP_W-1:0]   y_zero;
  logic [OP_W-1:0]   xs [100];
  logic [OP_W-1:0]   ys [100];
  logic [OP_W-1:0]   prev_x, prev_y;
  logic [PROD_W-1:0] exp_p;
  limb_t             ones_limb;
  int                live;

  initial begin
    // Reset held with nonzero operands
    bus.X = rand_op();
    bus.Y = rand_op();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < N_LIMBS; i++) begin
      check($sformatf("rst_a_chunk%0d", i), ext_chunk(a_ch[i]), '0);
      check($sformatf("rst_b_chunk%0d", i), ext_chunk(b_ch[i]), '0);
    end
    check("rst_product", bus.product, '0);

    // Hand-computed split and product
    x_dir = '0;
    for (int i = 0; i < N_LIMBS; i++) x_dir[LIMB_W*i +: LIMB_W] = LIMB_W'(exp_ch[i]);
    bus.X = x_dir;
    bus.Y = x_dir;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N_LIMBS; i++) begin
      check($sformatf("dir_a_chunk%0d", i), ext_chunk(a_ch[i]), PROD_W'(exp_ch[i]));
      check($sformatf("dir_b_chunk%0d", i), ext_chunk(b_ch[i]), PROD_W'(exp_ch[i]));
    end
    check("dir_product_not_yet", bus.product, '0);
    tick();
    exp_p = '0;
    for (int k = 0; k < 16; k++) exp_p[128*k +: 128] = 128'(exp_pl[k]);
    check("dir_product", bus.product, exp_p);

    // All-ones operands
    bus.X = '1;
    bus.Y = '1;
    tick();
    ones_limb = '1;
    check("ones_a_chunk7", ext_chunk(a_ch[7]), ext_limb(ones_limb));
    check("ones_b_chunk0", ext_chunk(b_ch[0]), ext_limb(ones_limb));
    tick();
    exp_p = '0;
    exp_p[127:0] = 128'd1;
    exp_p[128*8 +: 128] = {{127{1'b1}}, 1'b0};
    for (int k = 9; k < 16; k++) exp_p[128*k +: 128] = '1;
    check("ones_product", bus.product, exp_p);

    // Zero operand
    y_zero = rand_op();
    bus.X = '0;
    bus.Y = y_zero;
    tick();
    for (int i = 0; i < N_LIMBS; i++) begin
      check($sformatf("zero_b_chunk%0d", i), ext_chunk(b_ch[i]), ext_limb(y_zero[LIMB_W*i +: LIMB_W]));
    end
    check("zero_a_chunk3", ext_chunk(a_ch[3]), '0);
    tick();
    check("zero_product", bus.product, '0);

    // Back-to-back stream with a reset in the middle
    for (int c = 0; c < 100; c++) begin
      xs[c] = rand_op();
      ys[c] = rand_op();
    end
    prev_x = '0;
    prev_y = y_zero;
    live = 1;
    for (int c = 0; c < 100; c++) begin
      bus.X = xs[c];
      bus.Y = ys[c];
      tick();
      live++;
      check($sformatf("b2b_a_chunk%0d_c%0d", c % 8, c), ext_chunk(a_ch[c % 8]),
            ext_limb(xs[c][LIMB_W*(c % 8) +: LIMB_W]));
      check($sformatf("b2b_b_chunk%0d_c%0d", (c + 3) % 8, c), ext_chunk(b_ch[(c + 3) % 8]),
            ext_limb(ys[c][LIMB_W*((c + 3) % 8) +: LIMB_W]));
      if (live >= 2) check($sformatf("b2b_product_c%0d", c), bus.product, ref_mul(prev_x, prev_y));
      else           check($sformatf("b2b_product_flushed_c%0d", c), bus.product, '0);
      prev_x = xs[c];
      prev_y = ys[c];
      if (c == 60) begin
        rst_n = 1'b0;
        #1;
        check("midrst_product", bus.product, '0);
        check("midrst_a_chunk0", ext_chunk(a_ch[0]), '0);
        check("midrst_b_chunk5", ext_chunk(b_ch[5]), '0);
        tick();
        check("midrst_held_product", bus.product, '0);
        rst_n = 1'b1;
        live = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
